// File: rtl/mux81_ser_if.sv
// Bus bundle for mux81_ser: parallel-word valid/ready intake and the
// serialized {data, select} beat stream with its own valid/ready pair.
//   in_valid/in_ready/in_data : parallel word handshake (in_data bit k -> channel k)
//   out_valid/out_ready/o     : beat handshake, o = {data bit, channel select}
//   o_last                    : current beat is the final channel of the word
//   busy                      : a word is being serialized
interface mux81_ser_if #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [CHANNELS-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [SEL_W:0]      o;
  logic                o_last;
  logic                busy;

  // Producer of parallel words / consumer of beats.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, o, o_last, busy
  );

  // The serializer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, o, o_last, busy
  );
endinterface

// File: rtl/mux81_ser.sv
// Sequential 8:1 multiplexer/serializer. Takes one parallel word over a
// valid/ready handshake and emits it one channel per beat as {data, select},
// channel 0 first. A new word may be accepted on the last beat of the current
// one, so words stream with no bubble.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux81_ser_if.slave (word intake, beat output, o_last, busy)
module mux81_ser #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  mux81_ser_if.slave   bus
);

  localparam int unsigned O_W = SEL_W + 1;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(CHANNELS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] word_q, word_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [O_W-1:0]      o_q, o_d;
  logic                o_last_q, o_last_d;

  logic                last_sel_c;
  logic                in_ready_c;
  logic [SEL_W-1:0]    sel_inc_c;

  // Word intake is open when idle, or on the final accepted beat of a word.
  always_comb begin
    last_sel_c = (sel_q == SEL_MAX);
    sel_inc_c  = sel_q + SEL_W'(1);
    in_ready_c = (state_q == IDLE) || (bus.out_ready && last_sel_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    sel_d    = sel_q;
    o_d      = o_q;
    o_last_d = o_last_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = SEND;
          word_d   = bus.in_data;
          sel_d    = '0;
          o_d      = {bus.in_data[0], {SEL_W{1'b0}}};
          o_last_d = 1'b0;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (!last_sel_c) begin
            sel_d    = sel_inc_c;
            o_d      = {word_q[sel_inc_c], sel_inc_c};
            o_last_d = (sel_inc_c == SEL_MAX);
          end else if (bus.in_valid) begin
            // Back-to-back: next word's channel 0 follows immediately.
            word_d   = bus.in_data;
            sel_d    = '0;
            o_d      = {bus.in_data[0], {SEL_W{1'b0}}};
            o_last_d = 1'b0;
          end else begin
            // o is zeroed so it never reflects stale data while idle.
            state_d  = IDLE;
            sel_d    = '0;
            o_d      = '0;
            o_last_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      sel_q    <= '0;
      o_q      <= '0;
      o_last_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      sel_q    <= sel_d;
      o_q      <= o_d;
      o_last_q <= o_last_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == SEND);
  assign bus.busy      = (state_q == SEND);
  assign bus.o         = o_q;
  assign bus.o_last    = o_last_q;

endmodule

// File: tb/tb_mux81_ser.sv
// Scoreboard bench for mux81_ser: directed words push their expected beats
// into a queue; a negedge monitor pops and compares every accepted beat.
module tb_mux81_ser;

  logic clk;
  logic rst_n;

  mux81_ser_if #(.CHANNELS(8), .SEL_W(3)) bus ();

  mux81_ser #(.CHANNELS(8), .SEL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected beat: {o_last, data, sel}.
  logic [4:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Hand-computed beat list for a word: channel k carries bit k, last at k==7.
  task automatic push_word(input logic [7:0] w, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      logic [2:0] s;
      s = 3'(k);
      exp_q.push_back({(k == 7), w[k], s});
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
  task automatic send_word(input logic [7:0] w, input logic [7:0] junk, input int nbeats);
    push_word(w, nbeats);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = junk;
  endtask

  // Counts edges until busy drops; bounded so a stuck DUT still reaches the summary.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (bus.busy) begin
      n_checks++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", bus.busy, cyc);
    end
  endtask

  // Scoreboard monitor: compares each accepted beat against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got %0h expected none at %0t", {bus.o_last, bus.o}, $time);
      end else begin
        check("beat", {27'd0, bus.o_last, bus.o}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.out_ready = 1'b1;

    // Reset with a word offered: nothing captured, reset outputs.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_o",         32'(bus.o),         32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Single word 1010_0110, full-rate.
    send_word(8'b1010_0110, 8'h00, 8);
    check("single_first_o", 32'(bus.o),      32'h0);
    check("single_last0",   32'(bus.o_last), 32'd0);
    wait_idle(cyc);
    check("single_len", 32'(cyc), 32'd8);
    check("single_end_o", 32'(bus.o), 32'd0);

    // Backpressure for 3 cycles while o shows 1010.
    send_word(8'b1010_0110, 8'h55, 8);
    repeat (2) begin @(posedge clk); #1; end
    check("bp_o_before", 32'(bus.o), 32'b1010);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_o",     32'(bus.o),         32'b1010);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    wait_idle(cyc);
    check("bp_remaining", 32'(cyc), 32'd6);

    // Back-to-back FF then 00 with in_valid held high.
    push_word(8'hFF, 8);
    push_word(8'h00, 8);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    @(posedge clk); #1;
    bus.in_data  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check("b2b_in_ready", 32'(bus.in_ready), 32'(k == 7));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("b2b_no_bubble", 32'(bus.out_valid), 32'd1);
    check("b2b_second_o",  32'(bus.o),         32'b0000);
    wait_idle(cyc);
    check("b2b_second_len", 32'(cyc), 32'd8);

    // Reset mid-word after three beats of A5.
    send_word(8'hA5, 8'h00, 3);
    repeat (3) begin @(posedge clk); #1; end
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_o",     32'(bus.o),         32'd0);
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    send_word(8'h01, 8'h00, 8);
    check("post_rst_first", 32'(bus.o), 32'b1000);
    wait_idle(cyc);

    // in_data changes while busy are ignored.
    send_word(8'hC3, 8'h3C, 8);
    wait_idle(cyc);
    check("ignore_len", 32'(cyc), 32'd8);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
